// File: rtl/shared_mem.sv
// -----------------------------------------------------------------------------
// shared_mem
//   Single-port storage array shared by NUM_PORTS requesters. A round-robin
//   arbiter grants at most one access per cycle. Every access walks through
//   IDLE -> (WAIT ...) -> RESP -> IDLE, so each access takes at least two cycles.
//
// Handshake (all ports): a requester raises read_enable and/or write_enable
//   and holds the request, address and write fields stable until the matching
//   one-cycle response pulse (read_valid / write_ready). It deasserts the
//   request in the cycle the pulse is seen. If read and write are both raised,
//   the write is serviced first and the read is granted later, so it sees the
//   new data.
//
// Optional feature: define SHARED_MEM_ERR_EN to add byte-address range
//   checking and the access_error output. Without it, high address bits are
//   ignored and accesses wrap around the array.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   address[p]            byte address of port p
//   read_enable[p]        read request, held until read_valid[p]
//   read_data[p]          read result, updated only on read_valid[p]
//   read_valid[p]         one-cycle read-response pulse
//   write_data[p]         write data
//   write_enable[p]       write request, held until write_ready[p]
//   write_wstrb[p]        byte-lane write strobes
//   write_ready[p]        one-cycle write-completion pulse
//   access_error[p]       (SHARED_MEM_ERR_EN only) out-of-range flag, pulses
//                         together with the response pulse
//   fsm_state             debug view of the access FSM (0 IDLE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module shared_mem #(
  parameter int NUM_PORTS    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   address,
  input  logic [NUM_PORTS-1:0]                   read_enable,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   read_data,
  output logic [NUM_PORTS-1:0]                   read_valid,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   write_data,
  input  logic [NUM_PORTS-1:0]                   write_enable,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] write_wstrb,
  output logic [NUM_PORTS-1:0]                   write_ready,
`ifdef SHARED_MEM_ERR_EN
  output logic [NUM_PORTS-1:0]                   access_error,
`endif
  output logic [1:0]                             fsm_state
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int OFF_W     = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int SPAN_BITS = OFF_W + IDX_W;
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W     = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [1:0]            state_q;
  logic [PTR_W-1:0]      last_q;     // last granted port; search starts after it
  logic [PTR_W-1:0]      gnt_q;      // port owning the read in flight
  logic [CNT_W-1:0]      cnt_q;      // WAIT cycles already spent
  logic [DATA_WIDTH-1:0] rd_buf;     // read word parked while in WAIT
  logic                  err_q;
  logic [NUM_PORTS-1:0]  err_pulse;

  logic [NUM_PORTS-1:0]  req;
  logic                  gnt_any;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W:0]        cand;
  logic                  gnt_is_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [IDX_W-1:0]      word_idx;
  logic                  oor;
  logic                  do_write;

  assign req       = read_enable | write_enable;
  assign fsm_state = state_q;

  // Round-robin search: first requester after last_q, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = {1'b0, last_q} + (PTR_W + 1)'(i);
      if (cand >= (PTR_W + 1)'(NUM_PORTS)) cand = cand - (PTR_W + 1)'(NUM_PORTS);
      if (!gnt_any && req[cand[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
  end

  // A port with both requests raised gets its write first.
  assign gnt_is_write = write_enable[gnt_idx];
  assign sel_addr     = address[gnt_idx];
  assign word_idx     = sel_addr[OFF_W +: IDX_W];

`ifdef SHARED_MEM_ERR_EN
  assign oor = (sel_addr >> SPAN_BITS) != '0;
  assign access_error = err_pulse;
`else
  assign oor = 1'b0;
  logic unused_err;
  assign unused_err = ^err_pulse;
`endif

  // Byte-offset bits (and, without range checking, high bits) are don't-care.
  logic unused_addr;
  assign unused_addr = ^address;

  assign do_write = !reset && (state_q == IDLE) && gnt_any && gnt_is_write && !oor;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (write_wstrb[gnt_idx][b]) mem[word_idx][b*8 +: 8] <= write_data[gnt_idx][b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= PTR_W'(NUM_PORTS - 1);
      gnt_q       <= '0;
      cnt_q       <= '0;
      rd_buf      <= '0;
      err_q       <= 1'b0;
      err_pulse   <= '0;
      read_valid  <= '0;
      write_ready <= '0;
      read_data   <= '0;
    end else begin
      read_valid  <= '0;
      write_ready <= '0;
      err_pulse   <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            last_q <= gnt_idx;
            gnt_q  <= gnt_idx;
            err_q  <= oor;
            if (gnt_is_write) begin
              write_ready[gnt_idx] <= 1'b1;
              err_pulse[gnt_idx]   <= oor;
              state_q              <= RESP;
            end else if (READ_LATENCY == 1) begin
              read_valid[gnt_idx]  <= 1'b1;
              read_data[gnt_idx]   <= oor ? '0 : mem[word_idx];
              err_pulse[gnt_idx]   <= oor;
              state_q              <= RESP;
            end else begin
              rd_buf  <= oor ? '0 : mem[word_idx];
              cnt_q   <= '0;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          // READ_LATENCY-1 cycles are spent here before the response.
          if (cnt_q == CNT_W'(READ_LATENCY - 2)) begin
            read_valid[gnt_q] <= 1'b1;
            read_data[gnt_q]  <= rd_buf;
            err_pulse[gnt_q]  <= err_q;
            state_q           <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mem.sv
// -----------------------------------------------------------------------------
// tb_shared_mem
//   Two instances: u_a (READ_LATENCY 1, 16-word array to exercise wrap-around
//   and range checks) and u_b (READ_LATENCY 3, default depth) for WAIT-state
//   timing and reset-abort behaviour. Expected read words are pushed to exp_q
//   when the request is driven and popped when the response arrives.
// -----------------------------------------------------------------------------
module tb_shared_mem;

  localparam int NP  = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 20;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_reset, b_reset;

  logic [NP-1:0][AW-1:0] a_addr, b_addr;
  logic [NP-1:0]         a_re, a_we, b_re, b_we;
  logic [NP-1:0][DW-1:0] a_wdata, a_rdata, b_wdata, b_rdata;
  logic [NP-1:0][3:0]    a_strb, b_strb;
  logic [NP-1:0]         a_rv, a_wr, b_rv, b_wr;
  logic [1:0]            a_state, b_state;
`ifdef SHARED_MEM_ERR_EN
  logic [NP-1:0]         a_err, b_err;
`endif

  shared_mem #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
               .DEPTH_WORDS(16), .READ_LATENCY(1)) u_a (
    .clk(clk), .reset(a_reset), .address(a_addr), .read_enable(a_re),
    .read_data(a_rdata), .read_valid(a_rv), .write_data(a_wdata),
    .write_enable(a_we), .write_wstrb(a_strb), .write_ready(a_wr),
`ifdef SHARED_MEM_ERR_EN
    .access_error(a_err),
`endif
    .fsm_state(a_state));

  shared_mem #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
               .DEPTH_WORDS(4096), .READ_LATENCY(3)) u_b (
    .clk(clk), .reset(b_reset), .address(b_addr), .read_enable(b_re),
    .read_data(b_rdata), .read_valid(b_rv), .write_data(b_wdata),
    .write_enable(b_we), .write_wstrb(b_strb), .write_ready(b_wr),
`ifdef SHARED_MEM_ERR_EN
    .access_error(b_err),
`endif
    .fsm_state(b_state));

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  int checks   = 0;
  int failures = 0;

  // ---------------- driver tasks (start and end on a negedge, DUT idle) ------
  task automatic a_write(input int p, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                         input logic [3:0] s, output int lat);
    int n; bit seen;
    a_addr[p] = ad; a_wdata[p] = d; a_strb[p] = s; a_we[p] = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < TMO) begin @(negedge clk); n++; seen = a_wr[p]; end
    a_we[p] = 1'b0;
    lat = seen ? n : -1;
    @(negedge clk);
  endtask

  task automatic a_read(input int p, input logic [AW-1:0] ad, output logic [DW-1:0] d,
                        output int lat, output logic err, output logic after);
    int n; bit seen;
    a_addr[p] = ad; a_re[p] = 1'b1;
    n = 0; seen = 1'b0; err = 1'b0;
    while (!seen && n < TMO) begin @(negedge clk); n++; seen = a_rv[p]; end
    d = a_rdata[p];
`ifdef SHARED_MEM_ERR_EN
    err = a_err[p];
`endif
    a_re[p] = 1'b0;
    lat = seen ? n : -1;
    @(negedge clk);
    after = a_rv[p];
  endtask

  task automatic b_write(input int p, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                         input logic [3:0] s, output int lat);
    int n; bit seen;
    b_addr[p] = ad; b_wdata[p] = d; b_strb[p] = s; b_we[p] = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < TMO) begin @(negedge clk); n++; seen = b_wr[p]; end
    b_we[p] = 1'b0;
    lat = seen ? n : -1;
    @(negedge clk);
  endtask

  task automatic b_read(input int p, input logic [AW-1:0] ad, output logic [DW-1:0] d,
                        output int lat);
    int n; bit seen;
    b_addr[p] = ad; b_re[p] = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < TMO) begin @(negedge clk); n++; seen = b_rv[p]; end
    d = b_rdata[p];
    b_re[p] = 1'b0;
    lat = seen ? n : -1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_rv !== 2'b00) begin failures++; $display("FAIL reset_a_rv got=%b exp=00", a_rv); end
    checks++; if (a_wr !== 2'b00) begin failures++; $display("FAIL reset_a_wr got=%b exp=00", a_wr); end
    checks++; if (a_rdata !== '0) begin failures++; $display("FAIL reset_a_rdata got=%h exp=0", a_rdata); end
    checks++; if (a_state !== S_IDLE) begin failures++; $display("FAIL reset_a_state got=%0d exp=0", a_state); end
    checks++; if (b_rdata !== '0 || b_rv !== 2'b00 || b_wr !== 2'b00) begin
      failures++; $display("FAIL reset_b_outputs got rv=%b wr=%b rdata=%h exp=0", b_rv, b_wr, b_rdata); end
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; logic [DW-1:0] d; logic e, after;
    a_write(0, 32'h10, 32'hDEADBEEF, 4'hF, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL basic_write_lat got=%0d exp=1", lat); end
    exp_q.push_back(32'hDEADBEEF);
    a_read(0, 32'h10, d, lat, e, after);
    exp_w = exp_q.pop_front();
    checks++; if (lat !== 1) begin failures++; $display("FAIL basic_read_lat got=%0d exp=1", lat); end
    checks++; if (d !== exp_w) begin failures++; $display("FAIL basic_read_data got=%h exp=%h", d, exp_w); end
    checks++; if (after !== 1'b0) begin failures++; $display("FAIL basic_valid_pulse got=%b exp=0", after); end
    checks++; if (a_rdata[0] !== exp_w) begin failures++; $display("FAIL basic_data_hold got=%h exp=%h", a_rdata[0], exp_w); end
  endtask

  task automatic test_strobe();
    int lat; logic [DW-1:0] d; logic e, after;
    a_write(1, 32'h20, 32'h11223344, 4'hF, lat);
    a_write(1, 32'h20, 32'hAABBCCDD, 4'h5, lat);
    exp_q.push_back(32'h11BB33DD);
    a_read(0, 32'h20, d, lat, e, after);
    exp_w = exp_q.pop_front();
    checks++; if (d !== exp_w) begin failures++; $display("FAIL strobe_merge got=%h exp=%h", d, exp_w); end
    a_write(0, 32'h20, 32'hFFFFFFFF, 4'h0, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL strobe_zero_handshake got=%0d exp=1", lat); end
    exp_q.push_back(32'h11BB33DD);
    a_read(1, 32'h20, d, lat, e, after);
    exp_w = exp_q.pop_front();
    checks++; if (d !== exp_w) begin failures++; $display("FAIL strobe_zero_unchanged got=%h exp=%h", d, exp_w); end
  endtask

  task automatic test_rd_wr_same_port();
    int lat, n, wr_cyc, rv_cyc; logic [DW-1:0] d;
    a_write(0, 32'h8, 32'h0, 4'hF, lat);
    a_addr[1] = 32'h8; a_wdata[1] = 32'h5A5A5A5A; a_strb[1] = 4'hF;
    a_we[1] = 1'b1; a_re[1] = 1'b1;
    exp_q.push_back(32'h5A5A5A5A);
    n = 0; wr_cyc = -1; rv_cyc = -1; d = '0;
    while (rv_cyc < 0 && n < TMO) begin
      @(negedge clk); n++;
      if (a_wr[1]) begin wr_cyc = n; a_we[1] = 1'b0; end
      if (a_rv[1]) begin rv_cyc = n; d = a_rdata[1]; a_re[1] = 1'b0; end
    end
    a_we[1] = 1'b0; a_re[1] = 1'b0;
    @(negedge clk);
    exp_w = exp_q.pop_front();
    checks++; if (wr_cyc !== 1) begin failures++; $display("FAIL rdwr_write_first got=%0d exp=1", wr_cyc); end
    checks++; if (rv_cyc !== 3) begin failures++; $display("FAIL rdwr_read_later got=%0d exp=3", rv_cyc); end
    checks++; if (d !== exp_w) begin failures++; $display("FAIL rdwr_read_data got=%h exp=%h", d, exp_w); end
  endtask

  task automatic test_back_to_back();
    int lat, nresp, p_seen; logic [DW-1:0] last0;
    a_write(0, 32'h0, 32'h0A0A0A0A, 4'hF, lat);
    a_write(1, 32'h4, 32'h0B0B0B0B, 4'hF, lat);
    a_reset = 1'b1; @(negedge clk); @(negedge clk);
    a_reset = 1'b0;
    a_addr[0] = 32'h0; a_addr[1] = 32'h4; a_re = 2'b11;
    for (int k = 0; k < 8; k++) exp_q.push_back(k[0] ? 32'h0B0B0B0B : 32'h0A0A0A0A);
    nresp = 0; last0 = '0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (a_rv != 2'b00) begin
        p_seen = a_rv[1] ? 1 : 0;
        exp_w = exp_q.pop_front();
        checks++; if (p_seen !== nresp % 2) begin failures++; $display("FAIL b2b_order resp=%0d got_port=%0d exp_port=%0d", nresp, p_seen, nresp % 2); end
        checks++; if (cyc !== 1 + 2 * nresp) begin failures++; $display("FAIL b2b_timing resp=%0d got_cycle=%0d exp_cycle=%0d", nresp, cyc, 1 + 2 * nresp); end
        checks++; if (a_rdata[p_seen] !== exp_w) begin failures++; $display("FAIL b2b_data resp=%0d got=%h exp=%h", nresp, a_rdata[p_seen], exp_w); end
        if (p_seen == 0) last0 = a_rdata[0];
        nresp++;
      end else if (nresp > 0) begin
        checks++; if (a_rdata[0] !== last0) begin failures++; $display("FAIL b2b_hold cycle=%0d got=%h exp=%h", cyc, a_rdata[0], last0); end
      end
    end
    a_re = 2'b00;
    @(negedge clk);
    checks++; if (nresp !== 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", nresp); end
    exp_q.delete();
  endtask

  task automatic test_raw_cross_port();
    int lat; logic [DW-1:0] d; logic e, after;
    a_write(0, 32'h30, 32'hCAFEF00D, 4'hF, lat);
    exp_q.push_back(32'hCAFEF00D);
    a_read(1, 32'h30, d, lat, e, after);
    exp_w = exp_q.pop_front();
    checks++; if (d !== exp_w) begin failures++; $display("FAIL raw_cross got=%h exp=%h", d, exp_w); end
  endtask

  task automatic test_addr_range();
    int lat; logic [DW-1:0] d; logic e, after;
    a_write(0, 32'h0, 32'h13572468, 4'hF, lat);
`ifdef SHARED_MEM_ERR_EN
    exp_q.push_back(32'h0);
    a_read(1, 32'h40, d, lat, e, after);
    exp_w = exp_q.pop_front();
    checks++; if (d !== exp_w) begin failures++; $display("FAIL oor_read_data got=%h exp=%h", d, exp_w); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_error_flag got=%b exp=1", e); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL oor_read_lat got=%0d exp=1", lat); end
    a_write(1, 32'h40, 32'hFFFFFFFF, 4'hF, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL oor_write_handshake got=%0d exp=1", lat); end
    exp_q.push_back(32'h13572468);
    a_read(0, 32'h0, d, lat, e, after);
    exp_w = exp_q.pop_front();
    checks++; if (d !== exp_w) begin failures++; $display("FAIL oor_storage_kept got=%h exp=%h", d, exp_w); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL inrange_error_flag got=%b exp=0", e); end
`else
    exp_q.push_back(32'h13572468);
    a_read(1, 32'h40, d, lat, e, after);
    exp_w = exp_q.pop_front();
    checks++; if (d !== exp_w) begin failures++; $display("FAIL wrap_read got=%h exp=%h", d, exp_w); end
    a_write(1, 32'h44, 32'h99887766, 4'hF, lat);
    exp_q.push_back(32'h99887766);
    a_read(0, 32'h4, d, lat, e, after);
    exp_w = exp_q.pop_front();
    checks++; if (d !== exp_w) begin failures++; $display("FAIL wrap_write got=%h exp=%h", d, exp_w); end
`endif
  endtask

  task automatic test_latency3();
    int lat; logic [DW-1:0] d;
    b_write(0, 32'h10, 32'h01020304, 4'hF, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL lat3_write got=%0d exp=1", lat); end
    exp_q.push_back(32'h01020304);
    b_read(1, 32'h10, d, lat);
    exp_w = exp_q.pop_front();
    checks++; if (lat !== 3) begin failures++; $display("FAIL lat3_read_lat got=%0d exp=3", lat); end
    checks++; if (d !== exp_w) begin failures++; $display("FAIL lat3_read_data got=%h exp=%h", d, exp_w); end
  endtask

  task automatic test_reset_abort();
    int n, first_port, first_cyc; logic [DW-1:0] d;
    b_addr[0] = 32'h10; b_re[0] = 1'b1;
    @(negedge clk);
    checks++; if (b_state !== S_WAIT) begin failures++; $display("FAIL abort_in_wait got=%0d exp=1", b_state); end
    b_reset = 1'b1; b_re = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (b_rv !== 2'b00 || b_rdata !== '0) begin
        failures++; $display("FAIL abort_outputs k=%0d got rv=%b rdata=%h exp=0", k, b_rv, b_rdata); end
    end
    b_reset = 1'b0;
    b_addr[0] = 32'h10; b_addr[1] = 32'h14; b_re = 2'b11;
    exp_q.push_back(32'h01020304);
    n = 0; first_port = -1; first_cyc = -1; d = '0;
    while (first_port < 0 && n < TMO) begin
      @(negedge clk); n++;
      if (b_rv != 2'b00) begin
        first_port = b_rv[0] ? 0 : 1; first_cyc = n; d = b_rdata[first_port];
        b_re[first_port] = 1'b0;
      end
    end
    exp_w = exp_q.pop_front();
    checks++; if (first_port !== 0) begin failures++; $display("FAIL abort_port0_first got=%0d exp=0", first_port); end
    checks++; if (first_cyc !== 3) begin failures++; $display("FAIL abort_first_lat got=%0d exp=3", first_cyc); end
    checks++; if (d !== exp_w) begin failures++; $display("FAIL abort_storage_kept got=%h exp=%h", d, exp_w); end
    n = 0;
    while (!b_rv[1] && n < TMO) begin @(negedge clk); n++; end
    b_re = 2'b00;
    checks++; if (!b_rv[1]) begin failures++; $display("FAIL abort_port1_served got=0 exp=1"); end
    @(negedge clk);
  endtask

  initial begin
    a_reset = 1'b1; b_reset = 1'b1;
    a_addr = '0; a_re = '0; a_we = '0; a_wdata = '0; a_strb = '0;
    b_addr = '0; b_re = '0; b_we = '0; b_wdata = '0; b_strb = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_strobe();
    test_rd_wr_same_port();
    test_back_to_back();
    test_raw_cross_port();
    test_addr_range();
    test_latency3();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_mem.md
SHARED_MEM -- requirements
Module: shared_mem

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester ports (1..8).
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits (multiple of 8).
REQ-003 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-004 Parameter DEPTH_WORDS, default 4096: storage depth in words (power of two).
REQ-005 Parameter READ_LATENCY, default 1: cycles from grant to read_valid (1..4).
REQ-006 clk  input  1: single clock; all state on rising edge.
REQ-007 reset  input  1: synchronous, active-high reset.
REQ-008 address  input  NUM_PORTS x ADDR_WIDTH: per-port byte address.
REQ-009 read_enable  input  NUM_PORTS: per-port read request, held until read_valid.
REQ-010 read_data  output  NUM_PORTS x DATA_WIDTH: per-port read data.
REQ-011 read_valid  output  NUM_PORTS: one-cycle read-response pulse.
REQ-012 write_data  input  NUM_PORTS x DATA_WIDTH: per-port write data.
REQ-013 write_enable  input  NUM_PORTS: per-port write request, held until write_ready.
REQ-014 write_wstrb  input  NUM_PORTS x DATA_WIDTH/8: byte-lane write strobes.
REQ-015 write_ready  output  NUM_PORTS: one-cycle write-completion pulse.
REQ-016 access_error  output  NUM_PORTS: present only with SHARED_MEM_ERR_EN (REQ-036).

Function
REQ-017 One shared single-port storage array; at most one access (grant) per cycle.
REQ-018 FSM states IDLE, WAIT, RESP; IDLE grants when any port requests, else stays IDLE.
REQ-019 Arbitration round-robin: search starts at port after last granted; ties impossible.
REQ-020 Write grant: bytes with write_wstrb set written in grant cycle; FSM -> RESP; write_ready pulses next cycle.
REQ-021 Read grant: FSM -> WAIT for READ_LATENCY-1 cycles (skipped when 1), then RESP; read_valid pulses READ_LATENCY cycles after grant.
REQ-022 RESP lasts exactly one cycle, then IDLE; no grant in RESP; minimum 2 cycles per access.
REQ-023 read_data of a port updates only at its read_valid pulse and holds until its next read response.
REQ-024 Port asserting read_enable and write_enable together: write serviced first; read remains pending, arbitrated as separate later grant, observing the new data.
REQ-025 Word index = address bits [log2(DEPTH_WORDS)+1 : 2] for DATA_WIDTH 32 (generally above byte-offset bits); byte-offset bits ignored.
REQ-026 Address bits above index ignored (wrap-around) unless SHARED_MEM_ERR_EN defined.
REQ-027 Request dropped by requester before response is a protocol violation; behaviour undefined, no hang beyond current access.
REQ-028 Write with write_wstrb all zero still handshakes (write_ready pulses), storage unchanged.
REQ-029 Read-after-write to same word from different ports returns written data.

Reset
REQ-030 reset: read_valid, write_ready, access_error, read_data all 0 next cycle.
REQ-031 reset: FSM -> IDLE, round-robin pointer so port 0 has highest priority, latency counter 0.
REQ-032 reset mid-access aborts it: no response pulse issued; completed write already committed stays.
REQ-033 Storage contents not cleared by reset.

Configuration
REQ-034 Macro SHARED_MEM_ERR_EN selects address range checking.
REQ-035 Without it: access_error absent, out-of-range addresses wrap per REQ-026.
REQ-036 With it: address >= DEPTH_WORDS*DATA_WIDTH/8 still handshakes normally, storage untouched, read_data returns 0, access_error pulses with that port's read_valid/write_ready.

Verification
REQ-037 Port0 write addr 0x10 data 0xDEADBEEF wstrb 0xF, then port0 read 0x10 -> write_ready 1 cycle after grant; read_valid READ_LATENCY after grant; read_data 0xDEADBEEF.
REQ-038 Both ports request continuously from reset, NUM_PORTS=2 -> grants alternate 0,1,0,1; each port gets one response per 4 cycles (READ_LATENCY=1).
REQ-039 Word 0x20 = 0x11223344, write 0xAABBCCDD wstrb 0x5 -> read returns 0x11BB33DD.
REQ-040 Port1 simultaneous read+write addr 0x8 data 0x5A5A5A5A -> write_ready first, later read_valid with 0x5A5A5A5A.
REQ-041 Reset asserted in WAIT with READ_LATENCY=3 -> no read_valid; outputs 0; next request granted port 0 first.
REQ-042 DEPTH_WORDS=16, read address 0x40: without macro returns word 0; with SHARED_MEM_ERR_EN read_data 0, access_error 1 for one cycle.
